// File: rtl/mole_timer.sv
// Per-mole millisecond timer: prescaled 1 ms tick, saturating up/down count, tick/expiry pulses.
// Define MOLE_TIMER_RANDOM_EN to take the down-load value from a 16-bit LFSR instead of MAX_MS.
module mole_timer #(
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned MAX_MS      = 2047,
  parameter int unsigned MIN_MS      = 250
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      reset,
  input  logic                      up,
  input  logic                      enable,
  output logic [$clog2(MAX_MS)-1:0] timer_value,
  output logic                      ms_tick,
  output logic                      expired
);

  localparam int unsigned W  = $clog2(MAX_MS);
  localparam int unsigned PW = $clog2(CLKS_PER_MS);

  localparam logic [W-1:0]  MaxVal    = W'(MAX_MS);
  localparam logic [W-1:0]  MaxValM1  = W'(MAX_MS - 1);
  localparam logic [W-1:0]  MinVal    = W'(MIN_MS);
  localparam logic [PW-1:0] PrescLast = PW'(CLKS_PER_MS - 1);

  logic [PW-1:0] r_presc, w_presc_d;
  logic [W-1:0]  r_value, w_value_d;
  logic          r_tick, w_tick_d;
  logic          r_expired, w_expired_d;
  logic [W-1:0]  w_load;

`ifdef MOLE_TIMER_RANDOM_EN
  logic [15:0]  r_lfsr;
  logic         w_fb;
  logic [W-1:0] w_c;

  // Right-shifting Fibonacci form of taps 16/14/13/11.
  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  // Fold the raw sample into [MIN_MS, MAX_MS]; c + MIN_MS cannot exceed MAX_MS.
  always_comb begin
    w_c = r_lfsr[W-1:0];
    if (w_c < MinVal) begin
      w_load = w_c + MinVal;
    end else if (w_c > MaxVal) begin
      w_load = MaxVal;
    end else begin
      w_load = w_c;
    end
  end
`else
  assign w_load = MaxVal;
`endif

  always_comb begin
    w_presc_d   = r_presc;
    w_value_d   = r_value;
    w_tick_d    = 1'b0;
    w_expired_d = 1'b0;
    if (reset) begin
      w_presc_d = '0;
      w_value_d = up ? '0 : w_load;
    end else if (enable) begin
      if (r_presc == PrescLast) begin
        w_presc_d = '0;
        w_tick_d  = 1'b1;
        // Saturated steps still tick but never re-raise expired.
        if (up) begin
          if (r_value != MaxVal) begin
            w_value_d   = r_value + W'(1);
            w_expired_d = (r_value == MaxValM1);
          end
        end else if (r_value != '0) begin
          w_value_d   = r_value - W'(1);
          w_expired_d = (r_value == W'(1));
        end
      end else begin
        w_presc_d = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_value   <= '0;
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_presc   <= w_presc_d;
      r_value   <= w_value_d;
      r_tick    <= w_tick_d;
      r_expired <= w_expired_d;
    end
  end

  assign timer_value = r_value;
  assign ms_tick     = r_tick;
  assign expired     = r_expired;

endmodule

// File: tb/tb_mole_timer.sv
// Directed bench for mole_timer with CLKS_PER_MS=4, MAX_MS=15, MIN_MS=4.
// Constant-load scenarios run by default; the LFSR scenario runs when MOLE_TIMER_RANDOM_EN is set.
module tb_mole_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reset;
  logic       up;
  logic       enable;
  logic [3:0] timer_value;
  logic       ms_tick;
  logic       expired;

  int checks = 0;
  int errors = 0;

  logic [5:0] got;
  logic [5:0] want;

  mole_timer #(
    .CLKS_PER_MS(4),
    .MAX_MS     (15),
    .MIN_MS     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reset      (reset),
    .up         (up),
    .enable     (enable),
    .timer_value(timer_value),
    .ms_tick    (ms_tick),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic dir);
    reset  = 1'b1;
    up     = dir;
    enable = 1'b0;
    step();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reset = 1'b0; up = 1'b0; enable = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      got = {timer_value, ms_tick, expired};
      checks++;
      if (got !== 6'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d got %0d/%0b/%0b want 0/0/0", k, timer_value, ms_tick, expired);
      end
    end
  endtask

  task automatic test_down_count();
    load(1'b0);
    checks++;
    if (timer_value !== 4'd15) begin
      errors++;
      $display("FAIL down_load got %0d want 15", timer_value);
    end
    enable = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      step();
      want = {(k >= 60) ? 4'd0 : 4'(15 - k / 4), (k % 4 == 0), (k == 60)};
      got  = {timer_value, ms_tick, expired};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL down k=%0d got %0d/%0b/%0b want %0d/%0b/%0b", k, got[5:2], got[1],
                 got[0], want[5:2], want[1], want[0]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_pause();
    load(1'b0);
    enable = 1'b1;
    step();
    step();
    enable = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      got = {timer_value, ms_tick, expired};
      checks++;
      if (got !== {4'd15, 2'b00}) begin
        errors++;
        $display("FAIL pause k=%0d got %0d/%0b/%0b want 15/0/0", k, got[5:2], got[1], got[0]);
      end
    end
    enable = 1'b1;
    step();
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== {4'd15, 2'b00}) begin
      errors++;
      $display("FAIL resume1 got %0d/%0b/%0b want 15/0/0", got[5:2], got[1], got[0]);
    end
    step();
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== {4'd14, 2'b10}) begin
      errors++;
      $display("FAIL resume2 got %0d/%0b/%0b want 14/1/0", got[5:2], got[1], got[0]);
    end
    enable = 1'b0;
  endtask

  task automatic test_up_count();
    load(1'b1);
    checks++;
    if (timer_value !== 4'd0) begin
      errors++;
      $display("FAIL up_load got %0d want 0", timer_value);
    end
    up     = 1'b1;
    enable = 1'b1;
    for (int k = 1; k <= 68; k++) begin
      step();
      want = {(k >= 60) ? 4'd15 : 4'(k / 4), (k % 4 == 0), (k == 60)};
      got  = {timer_value, ms_tick, expired};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL up k=%0d got %0d/%0b/%0b want %0d/%0b/%0b", k, got[5:2], got[1],
                 got[0], want[5:2], want[1], want[0]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reload_mid();
    load(1'b0);
    enable = 1'b1;
    repeat (26) step();
    checks++;
    if (timer_value !== 4'd9) begin
      errors++;
      $display("FAIL reload_pre got %0d want 9", timer_value);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== {4'd15, 2'b00}) begin
      errors++;
      $display("FAIL reload got %0d/%0b/%0b want 15/0/0", got[5:2], got[1], got[0]);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      want = (k == 4) ? {4'd14, 2'b10} : {4'd15, 2'b00};
      got  = {timer_value, ms_tick, expired};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reload_step k=%0d got %0d/%0b/%0b want %0d/%0b/%0b", k, got[5:2],
                 got[1], got[0], want[5:2], want[1], want[0]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_dir_toggle();
    load(1'b0);
    enable = 1'b1;
    repeat (6) step();
    up = 1'b1;
    step();
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== {4'd14, 2'b00}) begin
      errors++;
      $display("FAIL toggle_pre got %0d/%0b/%0b want 14/0/0", got[5:2], got[1], got[0]);
    end
    step();
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== {4'd15, 2'b11}) begin
      errors++;
      $display("FAIL toggle_tick got %0d/%0b/%0b want 15/1/1", got[5:2], got[1], got[0]);
    end
    enable = 1'b0;
    up     = 1'b0;
  endtask

  task automatic test_rst_mid();
    load(1'b1);
    up     = 1'b1;
    enable = 1'b1;
    repeat (10) step();
    checks++;
    if (timer_value !== 4'd2) begin
      errors++;
      $display("FAIL rst_mid_pre got %0d want 2", timer_value);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {timer_value, ms_tick, expired};
    checks++;
    if (got !== 6'd0) begin
      errors++;
      $display("FAIL rst_mid got %0d/%0b/%0b want 0/0/0", got[5:2], got[1], got[0]);
    end
    step();
    rst_n  = 1'b1;
    enable = 1'b0;
    up     = 1'b0;
  endtask

`ifdef MOLE_TIMER_RANDOM_EN
  int         gap    [200];
  logic [3:0] vals_a [200];
  logic [3:0] vals_b [200];

  task automatic run_loads(input int pass);
    rst_n = 1'b0; reset = 1'b0; up = 1'b0; enable = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat (gap[i]) step();
      load(1'b0);
      if (pass == 0) vals_a[i] = timer_value;
      else           vals_b[i] = timer_value;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) gap[i] = $urandom_range(0, 5);
    run_loads(0);
    run_loads(1);
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (vals_a[i] < 4'd4 || vals_a[i] > 4'd15) begin
        errors++;
        $display("FAIL rand_range i=%0d got %0d want 4..15", i, vals_a[i]);
      end
      checks++;
      if (vals_b[i] !== vals_a[i]) begin
        errors++;
        $display("FAIL rand_repeat i=%0d got %0d want %0d", i, vals_b[i], vals_a[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_up_count();
    test_rst_mid();
`ifdef MOLE_TIMER_RANDOM_EN
    test_random();
`else
    test_down_count();
    test_pause();
    test_reload_mid();
    test_dir_toggle();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
